vram_port_arbiter: RTL

//  Front end that feeds a single-port, clock-enabled block RAM (1-cycle registered read).

---
 rtl/vram_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Front end for a single-port, clock-enabled block RAM with a one-cycle
//   registered read. Video scan reads and CPU read/write cycles share the
//   one RAM port. Video always wins. The CPU waits for a cycle with no video
//   request. After reset the RAM can be zero-filled before any access is
//   served.
//
// Parameters
//   ADDR_W          RAM address width (depth is 2**ADDR_W)
//   DATA_W          RAM data width
//   CLEAR_ON_RESET  1: zero-fill the RAM after reset, 0: start in IDLE
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   vid_req / vid_addr       video read request (one per cycle) and address
//   vid_rdata / vid_valid    video read data (straight from ram_q) and its qualifier
//   cpu_req / cpu_we         CPU access request (level, held until cpu_ack), write flag
//   cpu_addr / cpu_wdata     CPU address and write data
//   cpu_rdata / cpu_ack      registered CPU read data, one-cycle completion pulse
//   init_done                high once the clear sequence has finished
//   ram_addr/clken/wren/data registered RAM control outputs
//   ram_q                    RAM read data, valid the cycle after the RAM edge

module vram_port_arbiter #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              init_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_clken,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_full;
  logic              cpu_busy;
  logic              cpu_s1;
  logic              cpu_s2;
  logic              cpu_we_s1;
  logic              cpu_we_s2;
  logic              vid_s1;

  // Video data comes straight from the RAM; vid_valid says when it is meaningful.
  assign vid_rdata = ram_q;

  // Whole block is one registered state machine. The two small shift chains
  // (vid_s1 -> vid_valid, cpu_s1 -> cpu_s2 -> cpu_ack) track each issued
  // access through the RAM's capture edge so that the qualifiers line up with
  // ram_q. The clear counter saturates at the last address. clr_full marks
  // that the final write has been issued, so the following edge can drop the
  // clock enable and hand over to IDLE.
  // The CPU may be re-issued on the very edge that ends its ack cycle. That is
  // why "not busy" also accepts the cycle in which cpu_ack is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr  <= '0;
      clr_full  <= 1'b0;
      cpu_busy  <= 1'b0;
      cpu_s1    <= 1'b0;
      cpu_s2    <= 1'b0;
      cpu_we_s1 <= 1'b0;
      cpu_we_s2 <= 1'b0;
      vid_s1    <= 1'b0;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      init_done <= 1'b0;
      ram_addr  <= '0;
      ram_clken <= 1'b0;
      ram_wren  <= 1'b0;
      ram_data  <= '0;
    end else begin
      ram_clken <= 1'b0;
      ram_wren  <= 1'b0;
      vid_s1    <= 1'b0;
      cpu_s1    <= 1'b0;
      cpu_s2    <= cpu_s1;
      cpu_we_s2 <= cpu_we_s1;
      vid_valid <= vid_s1;
      cpu_ack   <= cpu_s2;
      if (cpu_s2 && !cpu_we_s2) begin
        cpu_rdata <= ram_q;
      end
      if (cpu_ack) begin
        cpu_busy <= 1'b0;
      end

      case (state)
        ST_CLEAR: begin
          if (!clr_full) begin
            ram_addr  <= clr_addr;
            ram_clken <= 1'b1;
            ram_wren  <= 1'b1;
            ram_data  <= '0;
            if (clr_addr == LAST_ADDR) begin
              clr_full <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end else begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          init_done <= 1'b1;
          if (vid_req) begin
            ram_addr  <= vid_addr;
            ram_clken <= 1'b1;
            ram_wren  <= 1'b0;
            ram_data  <= '0;
            vid_s1    <= 1'b1;
          end else if (cpu_req && (!cpu_busy || cpu_ack)) begin
            ram_addr  <= cpu_addr;
            ram_clken <= 1'b1;
            ram_wren  <= cpu_we;
            ram_data  <= cpu_wdata;
            cpu_s1    <= 1'b1;
            cpu_we_s1 <= cpu_we;
            cpu_busy  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
